gpmc_master: RTL and testbench

- Initiator side of the GPMC multiplexed address/data bus: turns a simple REQ/READY request port into GPMC single-word read/write cycles toward an SRAM-style GPMC target.
- Used as the FPGA-side bus driver when the FPGA owns the bus (bring-up, loopback against the GPMC SRAM target, FPGA-to-FPGA links).
- Synchronous GPMC timing only: GPMC_CLK is generated at CLK/2 during transactions; all GPMC strobes are active-low.

---
 rtl/gpmc_pkg.sv | 43 ++++
 rtl/gpmc_cycle_timer.sv | 38 +++
 rtl/gpmc_master.sv | 184 ++++++++++++++++++
 tb/tb_gpmc_master.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpmc_pkg.sv
// Shared types and constants for the GPMC initiator.
// Strobe levels are active-low; DIR=1 means the master drives AD.
package gpmc_pkg;

    localparam int GPMC_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_TURN
    } state_t;

    localparam logic STB_OFF = 1'b1;
    localparam logic STB_ON  = 1'b0;
    localparam logic DIR_OUT = 1'b1;
    localparam logic DIR_IN  = 1'b0;

    typedef struct packed {
        logic               cs;
        logic               adv;
        logic               oe;
        logic               we;
        logic               be1;
        logic               be0;
        logic               ad_oe;
        logic               dir;
        logic [GPMC_DW-1:0] ad;
    } bus_t;

    localparam bus_t BUS_IDLE = '{
        cs:    STB_OFF,
        adv:   STB_OFF,
        oe:    STB_OFF,
        we:    STB_OFF,
        be1:   STB_OFF,
        be0:   STB_OFF,
        ad_oe: 1'b0,
        dir:   DIR_IN,
        ad:    '0
    };

endpackage

// File: rtl/gpmc_cycle_timer.sv
// Phase toggle plus GPMC-cycle down-counter shared by all timed states.
// done_o flags the last ph=1 CLK of the loaded cycle count.
module gpmc_cycle_timer (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       run_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       extend_i,
    output logic       ph_o,
    output logic       done_o
);

    logic       ph_q;
    logic [3:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ph_q  <= 1'b0;
            cnt_q <= 4'd0;
        end else if (load_i) begin
            ph_q  <= 1'b0;
            cnt_q <= load_val_i;
        end else if (run_i) begin
            ph_q <= ~ph_q;
            // An extended cycle keeps its count; otherwise saturate at 0.
            if (ph_q && !extend_i && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end else begin
            ph_q <= 1'b0;
        end
    end

    assign ph_o   = ph_q;
    assign done_o = ph_q && (cnt_q <= 4'd1);

endmodule

// File: rtl/gpmc_master.sv
// GPMC multiplexed-bus initiator: REQ/READY port to single-word
// synchronous read/write cycles with wait extension and timeout.
module gpmc_master
    import gpmc_pkg::*;
#(
    parameter int ADV_CYC  = 1,
    parameter int ACC_CYC  = 2,
    parameter int TURN_CYC = 1,
    parameter int WAIT_MAX = 255
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               REQ,
    output logic               READY,
    input  logic               REQ_WE,
    input  logic [GPMC_DW-1:0] REQ_ADDR,
    input  logic [GPMC_DW-1:0] REQ_WDATA,
    input  logic [1:0]         REQ_BE,
    output logic               ACK,
    output logic               ERR,
    output logic [GPMC_DW-1:0] RDATA,
    output logic               GPMC_CLK,
    output logic [GPMC_DW-1:0] GPMC_AD_OUT,
    output logic               GPMC_AD_OE,
    input  logic [GPMC_DW-1:0] GPMC_AD_IN,
    output logic               GPMC_CS,
    output logic               GPMC_ADV,
    output logic               GPMC_OE,
    output logic               GPMC_WE,
    output logic               GPMC_BE0,
    output logic               GPMC_BE1,
    output logic               GPMC_WP,
    output logic               GPMC_DIR,
    input  logic               GPMC_WAIT
);

    state_t             state_q;
    bus_t               bus_q;
    logic               we_q;
    logic [GPMC_DW-1:0] wdata_q;
    logic [7:0]         wait_q;
    logic               ready_q;
    logic               ack_q;
    logic               err_q;
    logic               gclk_q;
    logic [GPMC_DW-1:0] rdata_q;

    logic       ph;
    logic       done;
    logic       accept;
    logic       wait_ext;
    logic       finish;
    logic       t_load;
    logic [3:0] t_val;

    assign accept   = (state_q == ST_IDLE) && REQ && ready_q;
    assign wait_ext = (state_q == ST_DATA) && done && GPMC_WAIT
                      && (wait_q != 8'(WAIT_MAX));
    assign finish   = (state_q == ST_DATA) && done && !wait_ext;

    always_comb begin
        t_load = 1'b0;
        t_val  = 4'(ADV_CYC);
        unique case (1'b1)
            accept: begin
                t_load = 1'b1;
                t_val  = 4'(ADV_CYC);
            end
            (state_q == ST_ADDR) && done: begin
                t_load = 1'b1;
                t_val  = 4'(ACC_CYC);
            end
            finish && (TURN_CYC != 0): begin
                t_load = 1'b1;
                t_val  = 4'(TURN_CYC);
            end
            default: ;
        endcase
    end

    gpmc_cycle_timer u_timer (
        .clk_i      (CLK),
        .rst_ni     (RST_N),
        .run_i      (state_q != ST_IDLE),
        .load_i     (t_load),
        .load_val_i (t_val),
        .extend_i   (wait_ext),
        .ph_o       (ph),
        .done_o     (done)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            bus_q   <= BUS_IDLE;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wait_q  <= 8'd0;
            ready_q <= 1'b1;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            gclk_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            // Transitions land on ph=1 edges, so ~ph is 0 when leaving.
            gclk_q <= (state_q == ST_ADDR || state_q == ST_DATA) ? ~ph : 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_ADDR;
                        ready_q <= 1'b0;
                        we_q    <= REQ_WE;
                        wdata_q <= REQ_WDATA;
                        wait_q  <= 8'd0;
                        bus_q   <= '{
                            cs:    STB_ON,
                            adv:   STB_ON,
                            oe:    STB_OFF,
                            we:    ~REQ_WE,
                            be1:   ~REQ_BE[1],
                            be0:   ~REQ_BE[0],
                            ad_oe: 1'b1,
                            dir:   DIR_OUT,
                            ad:    REQ_ADDR
                        };
                    end
                end
                ST_ADDR: begin
                    if (done) begin
                        state_q   <= ST_DATA;
                        bus_q.adv <= STB_OFF;
                        if (we_q) begin
                            bus_q.ad <= wdata_q;
                        end else begin
                            bus_q.ad_oe <= 1'b0;
                            bus_q.dir   <= DIR_IN;
                            bus_q.oe    <= STB_ON;
                        end
                    end
                end
                ST_DATA: begin
                    if (wait_ext) begin
                        wait_q <= wait_q + 8'd1;
                    end else if (finish) begin
                        ack_q   <= 1'b1;
                        err_q   <= GPMC_WAIT;
                        bus_q   <= BUS_IDLE;
                        state_q <= (TURN_CYC != 0) ? ST_TURN : ST_IDLE;
                        ready_q <= (TURN_CYC == 0);
                        if (!GPMC_WAIT && !we_q) begin
                            rdata_q <= GPMC_AD_IN;
                        end
                    end
                end
                ST_TURN: begin
                    if (done) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign READY       = ready_q;
    assign ACK         = ack_q;
    assign ERR         = err_q;
    assign RDATA       = rdata_q;
    assign GPMC_CLK    = gclk_q;
    assign GPMC_AD_OUT = bus_q.ad;
    assign GPMC_AD_OE  = bus_q.ad_oe;
    assign GPMC_CS     = bus_q.cs;
    assign GPMC_ADV    = bus_q.adv;
    assign GPMC_OE     = bus_q.oe;
    assign GPMC_WE     = bus_q.we;
    assign GPMC_BE0    = bus_q.be0;
    assign GPMC_BE1    = bus_q.be1;
    assign GPMC_DIR    = bus_q.dir;
    assign GPMC_WP     = 1'b1;

endmodule

// File: tb/tb_gpmc_master.sv
// Scenario bench for gpmc_master with a scoreboard of expected
// completions; WAIT_MAX is lowered to 4 so the timeout is reachable.
module tb_gpmc_master;

    localparam int WMAX = 4;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        REQ = 1'b0;
    logic        REQ_WE = 1'b0;
    logic [15:0] REQ_ADDR = '0;
    logic [15:0] REQ_WDATA = '0;
    logic [1:0]  REQ_BE = '0;
    logic [15:0] GPMC_AD_IN = '0;
    logic        GPMC_WAIT = 1'b0;

    logic        READY, ACK, ERR, GPMC_CLK, GPMC_AD_OE;
    logic [15:0] RDATA, GPMC_AD_OUT;
    logic        GPMC_CS, GPMC_ADV, GPMC_OE, GPMC_WE;
    logic        GPMC_BE0, GPMC_BE1, GPMC_WP, GPMC_DIR;

    gpmc_master #(
        .ADV_CYC  (1),
        .ACC_CYC  (2),
        .TURN_CYC (1),
        .WAIT_MAX (WMAX)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .REQ         (REQ),
        .READY       (READY),
        .REQ_WE      (REQ_WE),
        .REQ_ADDR    (REQ_ADDR),
        .REQ_WDATA   (REQ_WDATA),
        .REQ_BE      (REQ_BE),
        .ACK         (ACK),
        .ERR         (ERR),
        .RDATA       (RDATA),
        .GPMC_CLK    (GPMC_CLK),
        .GPMC_AD_OUT (GPMC_AD_OUT),
        .GPMC_AD_OE  (GPMC_AD_OE),
        .GPMC_AD_IN  (GPMC_AD_IN),
        .GPMC_CS     (GPMC_CS),
        .GPMC_ADV    (GPMC_ADV),
        .GPMC_OE     (GPMC_OE),
        .GPMC_WE     (GPMC_WE),
        .GPMC_BE0    (GPMC_BE0),
        .GPMC_BE1    (GPMC_BE1),
        .GPMC_WP     (GPMC_WP),
        .GPMC_DIR    (GPMC_DIR),
        .GPMC_WAIT   (GPMC_WAIT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          nack;
        logic [15:0] rd;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          last_acc = 0;
    logic [15:0] exp_rd = '0;

    // {cs, adv, oe, we, be1, be0, ad_oe, dir, gclk, ad}
    localparam logic [24:0] IDLE_V = {9'b111111000, 16'h0000};

    wire [24:0] bus = {GPMC_CS, GPMC_ADV, GPMC_OE, GPMC_WE,
                       GPMC_BE1, GPMC_BE0, GPMC_AD_OE, GPMC_DIR,
                       GPMC_CLK, GPMC_AD_OUT};

    function automatic logic [24:0] exp_vec(
        input int n, input int nack, input logic we,
        input logic [15:0] a, input logic [15:0] wd,
        input logic [1:0] be);
        if (n >= nack) return IDLE_V;
        if (n < 2)
            return {1'b0, 1'b0, 1'b1, ~we, ~be[1], ~be[0],
                    1'b1, 1'b1, n[0], a};
        return {1'b0, 1'b1, we, ~we, ~be[1], ~be[0],
                we, we, n[0], we ? wd : 16'h0000};
    endfunction

    // AD_OUT is not defined while the target owns the bus.
    function automatic logic [24:0] exp_mask(
        input int n, input int nack, input logic we);
        if (n >= 2 && n < nack && !we) return {9'h1ff, 16'h0000};
        return '1;
    endfunction

    task automatic xact(
        input logic we, input logic [15:0] a, input logic [15:0] wd,
        input logic [1:0] be, input logic [15:0] tgt, input int w,
        input bit keep, input string nm);
        int          ext, nack, k, n;
        bit          ab;
        exp_t        e, g;
        logic [24:0] ev, m;
        ab   = (w > WMAX);
        ext  = ab ? WMAX : w;
        nack = 6 + 2 * ext;
        REQ = 1'b1; REQ_WE = we; REQ_ADDR = a;
        REQ_WDATA = wd; REQ_BE = be;
        k = 0;
        while (READY !== 1'b1 && k < 40) begin
            @(posedge CLK); #1; k++;
        end
        if (READY !== 1'b1) begin
            total++; bad++;
            $display("FAIL %s ready_wait READY=%b want 1", nm, READY);
            REQ = 1'b0;
            return;
        end
        @(posedge CLK); #1;
        last_acc = cyc;
        e.nack = nack;
        e.rd   = (!we && !ab) ? tgt : exp_rd;
        e.err  = ab;
        exp_rd = e.rd;
        sb.push_back(e);
        if (!keep) REQ = 1'b0;
        else begin
            REQ_WE = ~we; REQ_ADDR = ~a;
            REQ_WDATA = ~wd; REQ_BE = ~be;
        end
        for (n = 0; n < 80; n++) begin
            if (n > 0) begin @(posedge CLK); #1; end
            ev = exp_vec(n, nack, we, a, wd, be);
            m  = exp_mask(n, nack, we);
            total++;
            if ((bus & m) !== (ev & m)) begin
                bad++;
                $display("FAIL %s bus n=%0d got=%h want=%h",
                         nm, n, bus & m, ev & m);
            end
            if (ACK === 1'b1) break;
            GPMC_WAIT  = ab || (n + 1 <= 5 + 2 * w);
            GPMC_AD_IN = (n + 1 == nack) ? tgt : ~tgt;
        end
        GPMC_WAIT = 1'b0;
        if (ACK !== 1'b1) begin
            total++; bad++;
            $display("FAIL %s ack_timeout ACK=%b want 1", nm, ACK);
            void'(sb.pop_front());
            return;
        end
        g = sb.pop_front();
        total++;
        if (n !== g.nack) begin
            bad++;
            $display("FAIL %s latency got=%0d want=%0d",
                     nm, n + 1, g.nack + 1);
        end
        total++;
        if (RDATA !== g.rd || ERR !== g.err || READY !== 1'b0) begin
            bad++;
            $display("FAIL %s ack_cycle rdata=%h err=%b rdy=%b want %h %b 0",
                     nm, RDATA, ERR, READY, g.rd, g.err);
        end
        @(posedge CLK); #1;
        total++;
        if (ACK !== 1'b0 || ERR !== 1'b0 || READY !== 1'b0
            || bus !== IDLE_V) begin
            bad++;
            $display("FAIL %s turn ack=%b err=%b rdy=%b bus=%h want 0 0 0 %h",
                     nm, ACK, ERR, READY, bus, IDLE_V);
        end
        @(posedge CLK); #1;
        total++;
        if (READY !== 1'b1 || RDATA !== g.rd) begin
            bad++;
            $display("FAIL %s idle rdy=%b rdata=%h want 1 %h",
                     nm, READY, RDATA, g.rd);
        end
    endtask

    task automatic test_reset();
        int acks;
        total++;
        if (bus !== IDLE_V || GPMC_WP !== 1'b1 || READY !== 1'b1
            || ACK !== 1'b0 || ERR !== 1'b0 || RDATA !== 16'h0) begin
            bad++;
            $display("FAIL reset_init bus=%h wp=%b rdy=%b ack=%b err=%b rd=%h",
                     bus, GPMC_WP, READY, ACK, ERR, RDATA);
        end
        @(negedge CLK) RST_N = 1'b1;
        @(posedge CLK); #1;
        REQ = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 16'h5555;
        REQ_WDATA = 16'h6666; REQ_BE = 2'b11;
        @(posedge CLK); #1;
        REQ = 1'b0;
        total++;
        if (GPMC_ADV !== 1'b0 || GPMC_AD_OUT !== 16'h5555) begin
            bad++;
            $display("FAIL reset_pre adv=%b ad=%h want 0 5555",
                     GPMC_ADV, GPMC_AD_OUT);
        end
        @(posedge CLK); #1;
        RST_N = 1'b0;
        #1;
        total++;
        if (bus !== IDLE_V || READY !== 1'b1 || ACK !== 1'b0
            || ERR !== 1'b0 || RDATA !== 16'h0) begin
            bad++;
            $display("FAIL reset_mid bus=%h rdy=%b ack=%b want %h 1 0",
                     bus, READY, ACK, IDLE_V);
        end
        @(negedge CLK);
        @(negedge CLK) RST_N = 1'b1;
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            if (ACK === 1'b1) acks++;
        end
        total++;
        if (acks != 0 || READY !== 1'b1 || bus !== IDLE_V) begin
            bad++;
            $display("FAIL reset_release acks=%0d rdy=%b want 0 1",
                     acks, READY);
        end
    endtask

    task automatic test_write();
        xact(1'b1, 16'h1234, 16'hA5A5, 2'b11, 16'h0, 0, 1'b0, "write");
    endtask

    task automatic test_read();
        xact(1'b0, 16'h0040, 16'h0, 2'b11, 16'hBEEF, 0, 1'b0, "read");
    endtask

    task automatic test_byte_write();
        xact(1'b1, 16'h0ABC, 16'h5A5A, 2'b10, 16'h0, 0, 1'b0, "byte_hi");
        xact(1'b0, 16'h0ABD, 16'h0, 2'b01, 16'h1357, 0, 1'b0, "byte_lo");
    endtask

    task automatic test_wait();
        xact(1'b0, 16'h0100, 16'h0, 2'b11, 16'hCAFE, 3, 1'b0, "wait3");
    endtask

    task automatic test_abort();
        xact(1'b0, 16'h0200, 16'h0, 2'b11, 16'hDEAD, 99, 1'b0, "abort");
        xact(1'b0, 16'h0300, 16'h0, 2'b11, 16'h2468, 1, 1'b0, "post_abort");
    endtask

    task automatic test_back_to_back();
        int a1;
        xact(1'b1, 16'h1111, 16'h2222, 2'b11, 16'h0, 0, 1'b1, "b2b_a");
        a1 = last_acc;
        xact(1'b0, 16'h3333, 16'h0, 2'b11, 16'h4444, 0, 1'b0, "b2b_b");
        total++;
        if (last_acc - a1 != 9) begin
            bad++;
            $display("FAIL b2b_spacing got=%0d want=9", last_acc - a1);
        end
    endtask

    initial begin
        #23;
        test_reset();
        test_write();
        test_read();
        test_byte_write();
        test_wait();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
